// File: rtl/channel_code_nco_if.sv
// Control/status bundle between the channel register file and the code NCO.
// Latency: pure wiring, no storage.
// Backpressure: none; every signal is a level or a single-cycle strobe.
interface channel_code_nco_if #(
    parameter int PHASE_WIDTH = 32,
    parameter int CHIP_WIDTH  = 32,
    parameter int EPOCH_WIDTH = 16
);
    logic                   enable;
    logic [PHASE_WIDTH-1:0] code_freq;
    logic                   freq_wr;
    logic [PHASE_WIDTH-1:0] phase_init;
    logic                   doinit;
    logic                   intr_pulse;
    logic                   prn_reset;
    logic                   shift;
    logic                   init_done;
    logic [PHASE_WIDTH-1:0] phase_latch;
    logic [CHIP_WIDTH-1:0]  chip_latch;
    logic [EPOCH_WIDTH-1:0] epoch_latch;
    logic                   latch_valid;

    // Register file / PRN stage side.
    modport master (
        output enable, code_freq, freq_wr, phase_init, doinit, intr_pulse, prn_reset,
        input  shift, init_done, phase_latch, chip_latch, epoch_latch, latch_valid
    );

    // NCO side.
    modport slave (
        input  enable, code_freq, freq_wr, phase_init, doinit, intr_pulse, prn_reset,
        output shift, init_done, phase_latch, chip_latch, epoch_latch, latch_valid
    );
endinterface

// File: rtl/channel_code_nco.sv
// Code NCO: phase accumulator emitting chip strobes, chip/epoch counters, intr_pulse snapshots.
// Latency: shift, init_done and latch_valid are registered, one clock after the causing edge.
// Backpressure: none; the downstream PRN stage must consume every shift strobe.
module channel_code_nco #(
    parameter int PHASE_WIDTH = 32,
    parameter int CHIP_WIDTH  = 32,
    parameter int EPOCH_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    channel_code_nco_if.slave  bus
);

    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] freq_reg;
    logic [CHIP_WIDTH-1:0]  chip_cnt;
    logic [EPOCH_WIDTH-1:0] epoch_cnt;
    logic                   shift_q;
    logic                   init_done_q;
    logic [PHASE_WIDTH-1:0] phase_latch_q;
    logic [CHIP_WIDTH-1:0]  chip_latch_q;
    logic [EPOCH_WIDTH-1:0] epoch_latch_q;
    logic                   latch_valid_q;

    // One extra bit so the accumulator overflow becomes the chip strobe.
    logic [PHASE_WIDTH:0]   sum;
    logic                   init_now;

    assign sum      = {1'b0, acc} + {1'b0, freq_reg};
    // No pending flag is kept: doinit is only looked at on the boundary strobe.
    assign init_now = bus.doinit & bus.intr_pulse;

    // Frequency word register; the add on the same edge still uses the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq_reg <= '0;
        end else if (bus.freq_wr) begin
            freq_reg <= bus.code_freq;
        end
    end

    // Phase accumulator and chip strobe; init overrides enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            shift_q <= 1'b0;
        end else if (init_now) begin
            acc     <= bus.phase_init;
            shift_q <= 1'b0;
        end else if (bus.enable) begin
            acc     <= sum[PHASE_WIDTH-1:0];
            shift_q <= sum[PHASE_WIDTH];
        end else begin
            shift_q <= 1'b0;
        end
    end

    // Chip-within-period and epoch counters; prn_reset arrives together with a strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chip_cnt  <= '0;
            epoch_cnt <= '0;
        end else if (init_now) begin
            chip_cnt  <= '0;
            epoch_cnt <= '0;
        end else if (bus.prn_reset) begin
            chip_cnt  <= '0;
            epoch_cnt <= epoch_cnt + 1'b1;
        end else if (shift_q) begin
            chip_cnt  <= chip_cnt + 1'b1;
        end
    end

    // Snapshot the pre-update register values on every boundary, init cycles included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_latch_q <= '0;
            chip_latch_q  <= '0;
            epoch_latch_q <= '0;
            latch_valid_q <= 1'b0;
            init_done_q   <= 1'b0;
        end else begin
            latch_valid_q <= bus.intr_pulse;
            init_done_q   <= init_now;
            if (bus.intr_pulse) begin
                phase_latch_q <= acc;
                chip_latch_q  <= chip_cnt;
                epoch_latch_q <= epoch_cnt;
            end
        end
    end

    assign bus.shift       = shift_q;
    assign bus.init_done   = init_done_q;
    assign bus.phase_latch = phase_latch_q;
    assign bus.chip_latch  = chip_latch_q;
    assign bus.epoch_latch = epoch_latch_q;
    assign bus.latch_valid = latch_valid_q;

endmodule

// File: tb/tb_channel_code_nco.sv
// Directed bench for channel_code_nco: strobe rates, enable hold, init, counters, snapshots, reset.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_channel_code_nco;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    channel_code_nco_if #(.PHASE_WIDTH(32), .CHIP_WIDTH(32), .EPOCH_WIDTH(16)) bus ();

    channel_code_nco #(.PHASE_WIDTH(32), .CHIP_WIDTH(32), .EPOCH_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.shift !== 1'b0 || bus.init_done !== 1'b0 || bus.latch_valid !== 1'b0) begin
            $display("FAIL reset_strobes shift=%b init_done=%b latch_valid=%b required 0/0/0",
                     bus.shift, bus.init_done, bus.latch_valid);
        end else passed++;
        total++;
        if (bus.phase_latch !== 32'h0 || bus.chip_latch !== 32'h0 || bus.epoch_latch !== 16'h0) begin
            $display("FAIL reset_latches phase=%h chip=%h epoch=%h required 0",
                     bus.phase_latch, bus.chip_latch, bus.epoch_latch);
        end else passed++;
        tick();
        reset = 1'b0;
    endtask

    // 0x4000_0000 -> one strobe every 4 clocks, first one 4 edges after the load edge.
    task automatic test_freq_rate();
        bus.enable    = 1'b1;
        bus.code_freq = 32'h4000_0000;
        bus.freq_wr   = 1'b1;
        tick();
        bus.freq_wr   = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            logic exp_s;
            tick();
            exp_s = (k % 4 == 0);
            total++;
            if (bus.shift !== exp_s) begin
                $display("FAIL rate_quarter k=%0d shift=%b required %b", k, bus.shift, exp_s);
            end else passed++;
        end
    endtask

    // 0xC000_0000 -> 0,1,1,1 pattern; then enable=0 holds phase and kills strobes.
    task automatic test_pattern_and_hold();
        bus.code_freq = 32'hC000_0000;
        bus.freq_wr   = 1'b1;
        tick();
        bus.freq_wr   = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            logic exp_s;
            tick();
            exp_s = (k == 1) ? 1'b1 : (((k - 2) % 4) != 0);
            total++;
            if (bus.shift !== exp_s) begin
                $display("FAIL rate_three_quarter k=%0d shift=%b required %b", k, bus.shift, exp_s);
            end else passed++;
        end
        bus.enable     = 1'b0;
        bus.intr_pulse = 1'b1;
        tick();
        bus.intr_pulse = 1'b0;
        total++;
        if (bus.phase_latch !== 32'hC000_0000 || bus.latch_valid !== 1'b1) begin
            $display("FAIL hold_snap1 phase_latch=%h latch_valid=%b required c0000000/1",
                     bus.phase_latch, bus.latch_valid);
        end else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (bus.shift !== 1'b0 || bus.latch_valid !== 1'b0) begin
                $display("FAIL hold_quiet k=%0d shift=%b latch_valid=%b required 0/0",
                         k, bus.shift, bus.latch_valid);
            end else passed++;
        end
        bus.intr_pulse = 1'b1;
        tick();
        bus.intr_pulse = 1'b0;
        total++;
        if (bus.phase_latch !== 32'hC000_0000 || bus.shift !== 1'b0) begin
            $display("FAIL hold_snap2 phase_latch=%h shift=%b required c0000000/0",
                     bus.phase_latch, bus.shift);
        end else passed++;
        bus.enable = 1'b1;
    endtask

    // doinit alone is ignored; doinit & intr_pulse loads phase_init and clears counters.
    task automatic test_init();
        do_reset();
        bus.enable    = 1'b1;
        bus.code_freq = 32'h8000_0000;
        bus.freq_wr   = 1'b1;
        tick();
        bus.freq_wr    = 1'b0;
        bus.doinit     = 1'b1;
        bus.phase_init = 32'hFFFF_FFFF;
        repeat (4) tick();
        bus.code_freq = 32'h0000_0001;
        bus.freq_wr   = 1'b1;
        tick();
        bus.freq_wr    = 1'b0;
        bus.intr_pulse = 1'b1;
        tick();
        bus.intr_pulse = 1'b0;
        bus.doinit     = 1'b0;
        total++;
        if (bus.init_done !== 1'b1 || bus.latch_valid !== 1'b1 || bus.shift !== 1'b0) begin
            $display("FAIL init_pulse init_done=%b latch_valid=%b shift=%b required 1/1/0",
                     bus.init_done, bus.latch_valid, bus.shift);
        end else passed++;
        total++;
        if (bus.phase_latch !== 32'h8000_0000 || bus.chip_latch !== 32'd2 || bus.epoch_latch !== 16'd0) begin
            $display("FAIL init_snap phase=%h chip=%0d epoch=%0d required 80000000/2/0",
                     bus.phase_latch, bus.chip_latch, bus.epoch_latch);
        end else passed++;
        tick();
        total++;
        if (bus.shift !== 1'b1 || bus.init_done !== 1'b0) begin
            $display("FAIL init_first_strobe shift=%b init_done=%b required 1/0",
                     bus.shift, bus.init_done);
        end else passed++;
        tick();
        bus.intr_pulse = 1'b1;
        tick();
        bus.intr_pulse = 1'b0;
        total++;
        if (bus.phase_latch !== 32'h1 || bus.chip_latch !== 32'd1 || bus.epoch_latch !== 16'd0) begin
            $display("FAIL init_after phase=%h chip=%0d epoch=%0d required 1/1/0",
                     bus.phase_latch, bus.chip_latch, bus.epoch_latch);
        end else passed++;
    endtask

    // 1023-chip periods, snapshot at chip 500 of the second period, then 3 epochs.
    task automatic test_epochs();
        int   chip;
        int   epoch;
        bit   pulsed;
        logic sh;
        do_reset();
        bus.enable    = 1'b1;
        bus.code_freq = 32'h8000_0000;
        bus.freq_wr   = 1'b1;
        tick();
        bus.freq_wr = 1'b0;
        chip = 0;
        epoch = 0;
        pulsed = 0;
        for (int cyc = 0; cyc < 8000 && epoch < 3; cyc++) begin
            sh = bus.shift;
            bus.prn_reset  = sh && (chip == 1022);
            bus.intr_pulse = !pulsed && (epoch == 1) && (chip == 500);
            tick();
            if (bus.intr_pulse) begin
                pulsed = 1;
                total++;
                if (bus.chip_latch !== 32'd500 || bus.epoch_latch !== 16'd1 || bus.latch_valid !== 1'b1) begin
                    $display("FAIL mid_period chip=%0d epoch=%0d latch_valid=%b required 500/1/1",
                             bus.chip_latch, bus.epoch_latch, bus.latch_valid);
                end else passed++;
            end
            if (bus.prn_reset) begin
                chip = 0;
                epoch++;
            end else if (sh) begin
                chip++;
            end
        end
        bus.prn_reset  = 1'b0;
        bus.intr_pulse = 1'b1;
        tick();
        bus.intr_pulse = 1'b0;
        total++;
        if (pulsed != 1 || epoch != 3 || bus.epoch_latch !== 16'd3 || bus.chip_latch !== 32'd0) begin
            $display("FAIL three_epochs epoch_latch=%0d chip_latch=%0d (mid snap seen=%0d) required 3/0/1",
                     bus.epoch_latch, bus.chip_latch, pulsed);
        end else passed++;
    endtask

    // intr_pulse on the prn_reset cycle: old counts snapshotted, counters still advance.
    task automatic test_coincident();
        int   chip;
        int   epoch;
        bit   hit;
        logic sh;
        do_reset();
        bus.enable    = 1'b1;
        bus.code_freq = 32'h8000_0000;
        bus.freq_wr   = 1'b1;
        tick();
        bus.freq_wr = 1'b0;
        chip = 0;
        epoch = 0;
        hit = 0;
        for (int cyc = 0; cyc < 20000 && !hit; cyc++) begin
            sh = bus.shift;
            bus.prn_reset  = sh && (chip == 1022);
            bus.intr_pulse = bus.prn_reset && (epoch == 7);
            hit = bus.intr_pulse;
            tick();
            if (bus.prn_reset) begin
                chip = 0;
                epoch++;
            end else if (sh) begin
                chip++;
            end
        end
        bus.prn_reset  = 1'b0;
        bus.intr_pulse = 1'b0;
        total++;
        if (hit != 1 || bus.chip_latch !== 32'd1022 || bus.epoch_latch !== 16'd7 || bus.latch_valid !== 1'b1) begin
            $display("FAIL coincident_snap chip=%0d epoch=%0d latch_valid=%b reached=%0d required 1022/7/1/1",
                     bus.chip_latch, bus.epoch_latch, bus.latch_valid, hit);
        end else passed++;
        bus.intr_pulse = 1'b1;
        tick();
        bus.intr_pulse = 1'b0;
        total++;
        if (bus.chip_latch !== 32'd0 || bus.epoch_latch !== 16'd8) begin
            $display("FAIL coincident_after chip=%0d epoch=%0d required 0/8",
                     bus.chip_latch, bus.epoch_latch);
        end else passed++;
    endtask

    // Asynchronous reset during a strobe, then restart with freq_reg cleared.
    task automatic test_reset_midrun();
        bit seen;
        seen = 0;
        for (int cyc = 0; cyc < 4 && !seen; cyc++) begin
            if (bus.shift === 1'b1) seen = 1;
            else tick();
        end
        total++;
        if (seen != 1) begin
            $display("FAIL midrun_strobe shift=%b required a strobe within 4 clocks", bus.shift);
        end else passed++;
        reset = 1'b1;
        #1;
        total++;
        if (bus.shift !== 1'b0 || bus.epoch_latch !== 16'd0 || bus.chip_latch !== 32'd0 ||
            bus.phase_latch !== 32'd0 || bus.latch_valid !== 1'b0 || bus.init_done !== 1'b0) begin
            $display("FAIL async_reset shift=%b phase=%h chip=%0d epoch=%0d valid=%b done=%b required all 0",
                     bus.shift, bus.phase_latch, bus.chip_latch, bus.epoch_latch,
                     bus.latch_valid, bus.init_done);
        end else passed++;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if (bus.shift !== 1'b0) begin
                $display("FAIL post_reset_quiet k=%0d shift=%b required 0", k, bus.shift);
            end else passed++;
        end
        bus.intr_pulse = 1'b1;
        tick();
        bus.intr_pulse = 1'b0;
        total++;
        if (bus.phase_latch !== 32'd0 || bus.chip_latch !== 32'd0 || bus.epoch_latch !== 16'd0) begin
            $display("FAIL post_reset_snap phase=%h chip=%0d epoch=%0d required 0/0/0",
                     bus.phase_latch, bus.chip_latch, bus.epoch_latch);
        end else passed++;
        bus.code_freq = 32'h4000_0000;
        bus.freq_wr   = 1'b1;
        tick();
        bus.freq_wr = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            logic exp_s;
            tick();
            exp_s = (k == 4);
            total++;
            if (bus.shift !== exp_s) begin
                $display("FAIL resume k=%0d shift=%b required %b", k, bus.shift, exp_s);
            end else passed++;
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset          = 1'b0;
        bus.enable     = 1'b0;
        bus.code_freq  = '0;
        bus.freq_wr    = 1'b0;
        bus.phase_init = '0;
        bus.doinit     = 1'b0;
        bus.intr_pulse = 1'b0;
        bus.prn_reset  = 1'b0;
        test_reset();
        test_freq_rate();
        test_pattern_and_hold();
        test_init();
        test_epochs();
        test_coincident();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
